fpu_result_buffer: RTL and testbench
====================================

Name: fpu_result_buffer

Overview:
- Downstream neighbour of the FPU top: captures every result/status/tag the FPU emits through its valid/ready output handshake.
- Buffers results in a small FIFO and presents them to the core writeback stage through a second valid/ready interface.
- Keeps a sticky floating-point exception flags register (fflags) for the CSR file, accumulated from results as they are accepted by writeback.
- Decouples FPU output back-pressure from writeback stalls.

Parameters:
- WIDTH, 32, result width in bits; matches the FPU datapath width.
- DEPTH, 4, FIFO entries; range 2..16, need not be a power of two.
- TAG_WIDTH, 5, width of the tag that travels with each result (destination register index).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous flush; discards all buffered entries.
- fpu_result_i  in  WIDTH  FPU result.
- fpu_status_i  in  5  FPU status {NV,DZ,OF,UF,NX}, NV at bit 4.
- fpu_tag_i  in  TAG_WIDTH  FPU result tag.
- fpu_valid_i  in  1  FPU output valid.
- fpu_ready_o  out  1  buffer can accept an entry.
- wb_result_o  out  WIDTH  head-entry result.
- wb_status_o  out  5  head-entry status.
- wb_tag_o  out  TAG_WIDTH  head-entry tag.
- wb_valid_o  out  1  head entry valid.
- wb_ready_i  in  1  writeback accepts the head entry.
- fflags_o  out  5  sticky OR of the status of all popped entries.
- fflags_clr_i  in  1  clear fflags (CSR write).
- count_o  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (rst_i high, asynchronous):
  - Pointers and count go to 0.
  - fpu_ready_o=1, wb_valid_o=0, fflags_o=0, count_o=0.
  - wb_result_o, wb_status_o and wb_tag_o are 0.
  - Storage contents are not reset.
- Push: fpu_valid_i && fpu_ready_o at a rising edge writes {result,status,tag} at the write pointer, advances it and increments count.
- Pop: wb_valid_o && wb_ready_i at a rising edge advances the read pointer and decrements count.
- Handshake rules:
  - fpu_ready_o = (count < DEPTH). It is registered state only and has no combinational path from wb_ready_i, so a full buffer refuses a push even when a pop happens in the same cycle.
  - wb_valid_o = (count != 0).
  - wb_* outputs show the head entry and are stable while wb_valid_o=1 and wb_ready_i=0.
- Latency: an entry pushed at edge N appears on wb_* after edge N; it can be popped at edge N+1 at the earliest.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointer wrap: each pointer goes from DEPTH-1 back to 0 by explicit compare, not power-of-two truncation.
- fflags:
  - On each pop, fflags <= fflags | wb_status_o.
  - fflags_clr_i alone: fflags <= 0.
  - fflags_clr_i together with a pop: fflags <= wb_status_o (clear first, then accumulate the popped entry).
  - Pushes never affect fflags.
- flush_i:
  - Next edge: count=0, pointers=0, wb_valid_o=0.
  - A push or pop in the same cycle is dropped.
  - fflags is not affected; a simultaneous fflags_clr_i still applies.
- Reset asserted mid-operation: all state returns to reset values immediately. No entry is popped and fflags is not updated in that cycle.

Optional Feature:
- Macro: FPU_RESULT_BUFFER_BYPASS_EN.
- When defined:
  - If count==0 and fpu_valid_i=1, the fpu_* inputs drive wb_* combinationally and wb_valid_o=1.
  - If wb_ready_i is also 1, the entry is consumed without being written and fflags accumulates it.
  - Otherwise the entry is written as a normal push.
  - fpu_ready_o is unchanged.
  - Zero-cycle latency when empty.
- When undefined: the minimum latency is 1 cycle, as described under Behaviour.

Decomposition:
- Package fpu_result_buffer_pkg holds:
  - Status bit index constants: NV=4, DZ=3, OF=2, UF=1, NX=0.
  - typedef status_t as logic [4:0].
  - A function entry_t builder parameterised on widths, or equivalent widths constants.
- One sub-module, fpu_result_buffer_fifo: the pointer/count/storage FIFO with flush.
- The top level wraps that FIFO and adds fflags accumulation and the bypass mux.

Test Plan:
- Single result: push {result=0x3F800000, status=5'b00001, tag=3} with wb_ready_i=1 → wb_valid_o rises the next cycle showing those values; after the pop fflags_o=5'b00001 and count_o=0.
- Fill with DEPTH=4: push 5 results back-to-back with wb_ready_i=0 → fpu_ready_o=0 after the 4th push and the 5th is held off by the FPU; then release wb_ready_i → entries come out in order with tags 0,1,2,3, and fpu_ready_o returns to 1 after the first pop.
- Push/pop at full: count=4, fpu_valid_i=1, wb_ready_i=1 → pop only, count=3 next cycle.
- fflags accumulation: pop statuses 5'b10000 then 5'b00100 → fflags_o=5'b10100; assert fflags_clr_i together with a pop of status 5'b00001 → fflags_o=5'b00001.
- Flush with count=3, plus a simultaneous push and pop → next cycle count_o=0, wb_valid_o=0, fflags_o unchanged.
- Asynchronous reset pulsed between clock edges with count=2 → wb_valid_o=0, count_o=0 and fflags_o=0 immediately. With FPU_RESULT_BUFFER_BYPASS_EN defined, an empty buffer with fpu_valid_i=1 and wb_ready_i=1 → same-cycle wb_valid_o=1 and count_o stays 0.

Source files
------------

// File: rtl/fpu_result_buffer_pkg.sv
// Shared definitions for the FPU result buffer: status bit layout and entry sizing.
package fpu_result_buffer_pkg;

  localparam int unsigned STATUS_WIDTH = 5;

  // Bit positions inside the {NV,DZ,OF,UF,NX} status vector.
  localparam int unsigned NV = 4;
  localparam int unsigned DZ = 3;
  localparam int unsigned OF = 2;
  localparam int unsigned UF = 1;
  localparam int unsigned NX = 0;

  typedef logic [STATUS_WIDTH-1:0] status_t;

  // Stored entry layout is {result, status, tag}.
  function automatic int unsigned entry_width(input int unsigned width,
                                              input int unsigned tag_width);
    return width + STATUS_WIDTH + tag_width;
  endfunction

endpackage

// File: rtl/fpu_result_buffer_fifo.sv
// Pointer/count FIFO with synchronous flush; storage itself is never reset.
module fpu_result_buffer_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en, pop_en;

  // Wrap by compare so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_en = push_i && !full_o && !flush_i;
  assign pop_en  = pop_i && !empty_o && !flush_i;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) wptr_d = next_ptr(wptr_q);
      if (pop_en)  rptr_d = next_ptr(rptr_q);
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fpu_result_buffer.sv
// FPU result buffer: FIFO between FPU output and writeback, plus sticky fflags.
// Optional zero-latency bypass when empty: define FPU_RESULT_BUFFER_BYPASS_EN.
module fpu_result_buffer
  import fpu_result_buffer_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             fpu_result_i,
  input  status_t                      fpu_status_i,
  input  logic [TAG_WIDTH-1:0]         fpu_tag_i,
  input  logic                         fpu_valid_i,
  output logic                         fpu_ready_o,
  output logic [WIDTH-1:0]             wb_result_o,
  output status_t                      wb_status_o,
  output logic [TAG_WIDTH-1:0]         wb_tag_o,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output status_t                      fflags_o,
  input  logic                         fflags_clr_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned EntryW = entry_width(WIDTH, TAG_WIDTH);

  logic [EntryW-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_push, pop_fire;
  status_t           fflags_q, fflags_d;

  fpu_result_buffer_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (fifo_push),
    .wdata_i ({fpu_result_i, fpu_status_i, fpu_tag_i}),
    .pop_i   (wb_ready_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  // Ready depends only on registered occupancy, never on wb_ready_i.
  assign fpu_ready_o = !fifo_full;

  always_comb begin
    {wb_result_o, wb_status_o, wb_tag_o} = fifo_rdata;
    wb_valid_o = !fifo_empty;
    fifo_push  = fpu_valid_i;
`ifdef FPU_RESULT_BUFFER_BYPASS_EN
    if (fifo_empty && fpu_valid_i) begin
      wb_result_o = fpu_result_i;
      wb_status_o = fpu_status_i;
      wb_tag_o    = fpu_tag_i;
      wb_valid_o  = 1'b1;
      // Consumed directly by writeback, so it never enters storage.
      if (wb_ready_i) fifo_push = 1'b0;
    end
`endif
  end

  assign pop_fire = wb_valid_o && wb_ready_i && !flush_i;

  // Clear takes effect before the popped entry is accumulated.
  always_comb begin
    fflags_d = fflags_q;
    if (fflags_clr_i) fflags_d = '0;
    if (pop_fire)     fflags_d = fflags_d | wb_status_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fflags_q <= '0;
    else       fflags_q <= fflags_d;
  end

  assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Directed self-checking bench for fpu_result_buffer (DEPTH=4).
module tb_fpu_result_buffer;

  logic        clk = 1'b0;
  logic        rst_i, flush_i;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic [4:0]  fpu_tag_i;
  logic        fpu_valid_i, fpu_ready_o;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_status_o, wb_tag_o;
  logic        wb_valid_o, wb_ready_i;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  fpu_result_buffer #(
    .WIDTH     (32),
    .DEPTH     (4),
    .TAG_WIDTH (5)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .fpu_result_i (fpu_result_i),
    .fpu_status_i (fpu_status_i),
    .fpu_tag_i    (fpu_tag_i),
    .fpu_valid_i  (fpu_valid_i),
    .fpu_ready_o  (fpu_ready_o),
    .wb_result_o  (wb_result_o),
    .wb_status_o  (wb_status_o),
    .wb_tag_o     (wb_tag_o),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .fflags_o     (fflags_o),
    .fflags_clr_i (fflags_clr_i),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] s,
                       input logic [4:0] t);
    fpu_valid_i  = v;
    fpu_result_i = r;
    fpu_status_i = s;
    fpu_tag_i    = t;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; fflags_clr_i = 1'b0; wb_ready_i = 1'b0;
    drive(1'b0, 32'h0, 5'h0, 5'h0);
    #1;
    check("rst_ready", 32'(fpu_ready_o), 32'd1);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_fflags", 32'(fflags_o), 32'b00000);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_wb_result", wb_result_o, 32'h0);
    check("rst_wb_tag", 32'(wb_tag_o), 32'd0);
    tick();
    tick();
    rst_i = 1'b0;

    // Single result with writeback ready.
    drive(1'b1, 32'h3F80_0000, 5'b00001, 5'd3);
    wb_ready_i = 1'b1;
    tick();
    drive(1'b0, 32'h0, 5'h0, 5'h0);
`ifdef FPU_RESULT_BUFFER_BYPASS_EN
    check("single_bypass_count", 32'(count_o), 32'd0);
    check("single_bypass_fflags", 32'(fflags_o), 32'b00001);
`else
    check("single_wb_valid", 32'(wb_valid_o), 32'd1);
    check("single_wb_result", wb_result_o, 32'h3F80_0000);
    check("single_wb_status", 32'(wb_status_o), 32'b00001);
    check("single_wb_tag", 32'(wb_tag_o), 32'd3);
    check("single_count1", 32'(count_o), 32'd1);
    tick();
    check("single_fflags", 32'(fflags_o), 32'b00001);
    check("single_count0", 32'(count_o), 32'd0);
    check("single_empty", 32'(wb_valid_o), 32'd0);
`endif

    // Fill: five back-to-back offers with writeback stalled.
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 5'h0, 5'(i));
      tick();
    end
    check("fill_count4", 32'(count_o), 32'd4);
    check("fill_ready0", 32'(fpu_ready_o), 32'd0);
    drive(1'b1, 32'h104, 5'h0, 5'd4);
    tick();
    check("fill_held_count", 32'(count_o), 32'd4);
    check("fill_head_stable", 32'(wb_tag_o), 32'd0);
    check("fill_head_result", wb_result_o, 32'h100);

    // Full with push and pop offered: only the pop happens.
    wb_ready_i = 1'b1;
    tick();
    check("full_pp_count3", 32'(count_o), 32'd3);
    check("full_pp_ready1", 32'(fpu_ready_o), 32'd1);
    check("drain_tag1", 32'(wb_tag_o), 32'd1);
    drive(1'b0, 32'h0, 5'h0, 5'h0);
    tick();
    check("drain_tag2", 32'(wb_tag_o), 32'd2);
    tick();
    check("drain_tag3", 32'(wb_tag_o), 32'd3);
    check("drain_result3", wb_result_o, 32'h103);
    tick();
    check("drain_count0", 32'(count_o), 32'd0);
    check("drain_fflags", 32'(fflags_o), 32'b00001);

    // fflags accumulation and clear-with-pop.
    wb_ready_i = 1'b0;
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    check("clr_alone", 32'(fflags_o), 32'b00000);
    drive(1'b1, 32'h1, 5'b10000, 5'd10); tick();
    drive(1'b1, 32'h2, 5'b00100, 5'd11); tick();
    drive(1'b1, 32'h3, 5'b00001, 5'd12); tick();
    drive(1'b0, 32'h0, 5'h0, 5'h0);
    check("ff_push_no_effect", 32'(fflags_o), 32'b00000);
    wb_ready_i = 1'b1;
    tick();
    check("ff_nv", 32'(fflags_o), 32'b10000);
    tick();
    check("ff_nv_of", 32'(fflags_o), 32'b10100);
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    check("ff_clr_pop", 32'(fflags_o), 32'b00001);
    check("ff_count0", 32'(count_o), 32'd0);

    // Flush with count=3 and a simultaneous push and pop.
    wb_ready_i = 1'b0;
    drive(1'b1, 32'h7, 5'b00010, 5'd20); tick();
    drive(1'b1, 32'h8, 5'b00000, 5'd21); tick();
    drive(1'b1, 32'h9, 5'b00000, 5'd22); tick();
    check("pre_flush_count", 32'(count_o), 32'd3);
    flush_i = 1'b1;
    wb_ready_i = 1'b1;
    drive(1'b1, 32'hA, 5'b01000, 5'd23);
    tick();
    flush_i = 1'b0;
    wb_ready_i = 1'b0;
    drive(1'b0, 32'h0, 5'h0, 5'h0);
    check("flush_count", 32'(count_o), 32'd0);
    check("flush_wb_valid", 32'(wb_valid_o), 32'd0);
    check("flush_fflags", 32'(fflags_o), 32'b00001);

    // Asynchronous reset between edges with count=2.
    drive(1'b1, 32'hB, 5'b00000, 5'd1); tick();
    drive(1'b1, 32'hC, 5'b00000, 5'd2); tick();
    drive(1'b0, 32'h0, 5'h0, 5'h0);
    check("pre_rst_count", 32'(count_o), 32'd2);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("arst_count", 32'(count_o), 32'd0);
    check("arst_fflags", 32'(fflags_o), 32'b00000);
    check("arst_ready", 32'(fpu_ready_o), 32'd1);
    #1;
    rst_i = 1'b0;

`ifdef FPU_RESULT_BUFFER_BYPASS_EN
    tick();
    drive(1'b1, 32'h55, 5'b01000, 5'd7);
    wb_ready_i = 1'b1;
    #1;
    check("byp_wb_valid", 32'(wb_valid_o), 32'd1);
    check("byp_wb_tag", 32'(wb_tag_o), 32'd7);
    check("byp_count", 32'(count_o), 32'd0);
    tick();
    drive(1'b0, 32'h0, 5'h0, 5'h0);
    check("byp_count_after", 32'(count_o), 32'd0);
    check("byp_fflags", 32'(fflags_o), 32'b01000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
